usbh_xfer_sched: RTL and testbench

- Sequences the USB host serial interface engine (SIE). Owns its start/token/control inputs and consumes its ack/status outputs.
- Arbitrates between an internal 1 ms SOF generator, which has priority, and a single host transfer-request port.
- Retries NAKed transfers automatically and enforces an end-of-frame guard window.
- Reports one completion record per host request.

---
 rtl/usbh_xfer_sched_if.sv | 52 +++++
 rtl/usbh_xfer_sched.sv | 170 +++++++++++++++++
 tb/tb_usbh_xfer_sched.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/usbh_xfer_sched_if.sv
// Request, completion and SIE sequencing bundle of the USB host transfer scheduler.
// slave: the scheduler itself; master: the host/SIE side that drives and observes it.
interface usbh_xfer_sched_if;
    logic        sof_en_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [7:0]  req_pid_i;
    logic [6:0]  req_dev_i;
    logic [3:0]  req_ep_i;
    logic [15:0] req_len_i;
    logic        req_in_i;
    logic        req_data1_i;
    logic        req_resp_i;
    logic        cpl_valid_o;
    logic [7:0]  cpl_resp_o;
    logic [1:0]  cpl_err_o;
    logic [15:0] cpl_rxcnt_o;
    logic [10:0] frame_o;
    logic        sie_start_o;
    logic        sie_in_o;
    logic        sie_sof_o;
    logic        sie_resp_o;
    logic        sie_data1_o;
    logic [7:0]  sie_pid_o;
    logic [6:0]  sie_dev_o;
    logic [3:0]  sie_ep_o;
    logic [15:0] sie_len_o;
    logic        sie_ack_i;
    logic        sie_idle_i;
    logic        sie_timeout_i;
    logic        sie_crcerr_i;
    logic [7:0]  sie_resp_i;
    logic [15:0] sie_rxcnt_i;

    modport slave (
        input  sof_en_i, req_valid_i, req_pid_i, req_dev_i, req_ep_i, req_len_i, req_in_i,
               req_data1_i, req_resp_i, sie_ack_i, sie_idle_i, sie_timeout_i, sie_crcerr_i,
               sie_resp_i, sie_rxcnt_i,
        output req_ready_o, cpl_valid_o, cpl_resp_o, cpl_err_o, cpl_rxcnt_o, frame_o,
               sie_start_o, sie_in_o, sie_sof_o, sie_resp_o, sie_data1_o, sie_pid_o,
               sie_dev_o, sie_ep_o, sie_len_o
    );

    modport master (
        output sof_en_i, req_valid_i, req_pid_i, req_dev_i, req_ep_i, req_len_i, req_in_i,
               req_data1_i, req_resp_i, sie_ack_i, sie_idle_i, sie_timeout_i, sie_crcerr_i,
               sie_resp_i, sie_rxcnt_i,
        input  req_ready_o, cpl_valid_o, cpl_resp_o, cpl_err_o, cpl_rxcnt_o, frame_o,
               sie_start_o, sie_in_o, sie_sof_o, sie_resp_o, sie_data1_o, sie_pid_o,
               sie_dev_o, sie_ep_o, sie_len_o
    );
endinterface

// File: rtl/usbh_xfer_sched.sv
// USB host SIE sequencer: SOF every frame (priority) plus one host request with NAK retry and EOF guard.
// Request accepted combinationally in IDLE only; held off by SOF pending, an owned request or the guard window.
module usbh_xfer_sched #(
    parameter int SOF_PERIOD = 60000,
    parameter int EOF_GUARD  = 6000,
    parameter int MAX_RETRY  = 15,
    parameter int RETRY_GAP  = 64
) (
    input  logic              clkout2,
    input  logic              reset,
    usbh_xfer_sched_if.slave  bus
);
    localparam int TW = (SOF_PERIOD > 2) ? $clog2(SOF_PERIOD) : 1;
    localparam int GW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SOF_GO, S_REQ_GO, S_BUSY, S_GAP, S_CPL} state_t;

    state_t        r_state, w_state_nxt;
    logic [TW-1:0] r_timer;
    logic [10:0]   r_frame;
    logic          r_sof_pend, r_is_sof, r_owned;
    logic [3:0]    r_retry;
    logic [GW-1:0] r_gap;
    logic [7:0]    r_pid;
    logic [6:0]    r_dev;
    logic [3:0]    r_ep;
    logic [15:0]   r_len;
    logic          r_in, r_data1, r_resp;
    logic [7:0]    r_cpl_resp;
    logic [1:0]    r_cpl_err;
    logic [15:0]   r_cpl_rxcnt;

    logic          w_wrap, w_room, w_accept, w_take_sof, w_busy_done, w_retry;
    logic [31:0]   w_remain;

    assign w_wrap      = bus.sof_en_i && (r_timer == TW'(SOF_PERIOD - 1));
    assign w_remain    = 32'(SOF_PERIOD - 1) - 32'(r_timer);
    assign w_room      = w_remain > 32'(EOF_GUARD);
    assign w_busy_done = (r_state == S_BUSY) && bus.sie_idle_i;
    assign w_retry     = (bus.sie_resp_i == 8'h5A) && (r_retry < 4'(MAX_RETRY));

    always_comb begin
        w_state_nxt     = r_state;
        w_accept        = 1'b0;
        w_take_sof      = 1'b0;
        bus.sie_start_o = 1'b0;
        bus.sie_sof_o   = 1'b0;
        bus.sie_in_o    = 1'b0;
        bus.sie_resp_o  = 1'b0;
        bus.sie_data1_o = 1'b0;
        bus.sie_pid_o   = 8'h00;
        bus.sie_dev_o   = 7'h00;
        bus.sie_ep_o    = 4'h0;
        bus.sie_len_o   = 16'h0000;
        case (r_state)
            S_IDLE: begin
                if (r_sof_pend) begin
                    w_take_sof  = 1'b1;
                    w_state_nxt = S_SOF_GO;
                end else if (r_owned && w_room) begin
                    w_state_nxt = S_REQ_GO;
                end else if (!r_owned && bus.req_valid_i && w_room) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_REQ_GO;
                end
            end
            S_SOF_GO: begin
                bus.sie_start_o = 1'b1;
                bus.sie_sof_o   = 1'b1;
                bus.sie_pid_o   = 8'hA5;
                bus.sie_dev_o   = r_frame[6:0];
                bus.sie_ep_o    = r_frame[10:7];
                if (bus.sie_ack_i) w_state_nxt = S_BUSY;
            end
            S_REQ_GO: begin
                bus.sie_start_o = 1'b1;
                bus.sie_in_o    = r_in;
                bus.sie_resp_o  = r_resp;
                bus.sie_data1_o = r_data1;
                bus.sie_pid_o   = r_pid;
                bus.sie_dev_o   = r_dev;
                bus.sie_ep_o    = r_ep;
                bus.sie_len_o   = r_len;
                if (bus.sie_ack_i) w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (bus.sie_idle_i) begin
                    if (r_is_sof)     w_state_nxt = S_IDLE;
                    else if (w_retry) w_state_nxt = S_GAP;
                    else              w_state_nxt = S_CPL;
                end
            end
            S_GAP:   if (r_gap == GW'(RETRY_GAP - 1)) w_state_nxt = S_IDLE;
            S_CPL:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.req_ready_o = w_accept;
    assign bus.cpl_valid_o = (r_state == S_CPL);
    assign bus.cpl_resp_o  = r_cpl_resp;
    assign bus.cpl_err_o   = r_cpl_err;
    assign bus.cpl_rxcnt_o = r_cpl_rxcnt;
    assign bus.frame_o     = r_frame;

    always_ff @(posedge clkout2 or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_frame     <= '0;
            r_sof_pend  <= 1'b0;
            r_is_sof    <= 1'b0;
            r_owned     <= 1'b0;
            r_retry     <= '0;
            r_gap       <= '0;
            r_pid       <= '0;
            r_dev       <= '0;
            r_ep        <= '0;
            r_len       <= '0;
            r_in        <= 1'b0;
            r_data1     <= 1'b0;
            r_resp      <= 1'b0;
            r_cpl_resp  <= '0;
            r_cpl_err   <= '0;
            r_cpl_rxcnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            // A wrap while an SOF is still pending just re-asserts the same single pending flag.
            if (!bus.sof_en_i) begin
                r_timer    <= '0;
                r_sof_pend <= 1'b0;
            end else if (w_wrap) begin
                r_timer    <= '0;
                r_frame    <= r_frame + 11'd1;
                r_sof_pend <= 1'b1;
            end else begin
                r_timer <= r_timer + 1'b1;
                if (w_take_sof) r_sof_pend <= 1'b0;
            end
            if (w_accept) begin
                r_pid   <= bus.req_pid_i;
                r_dev   <= bus.req_dev_i;
                r_ep    <= bus.req_ep_i;
                r_len   <= bus.req_len_i;
                r_in    <= bus.req_in_i;
                r_data1 <= bus.req_data1_i;
                r_resp  <= bus.req_resp_i;
                r_retry <= '0;
                r_owned <= 1'b1;
            end
            if (r_state == S_SOF_GO) r_is_sof <= 1'b1;
            if (r_state == S_REQ_GO) r_is_sof <= 1'b0;
            if (r_state == S_GAP)    r_gap    <= r_gap + 1'b1;
            if (w_busy_done && !r_is_sof) begin
                r_cpl_resp  <= bus.sie_resp_i;
                r_cpl_rxcnt <= bus.sie_rxcnt_i;
                if (w_retry) begin
                    r_retry <= r_retry + 4'd1;
                    r_gap   <= '0;
                end else begin
                    r_owned <= 1'b0;
                    if (bus.sie_resp_i == 8'h5A) r_cpl_err <= 2'd3;
                    else if (bus.sie_timeout_i)  r_cpl_err <= 2'd1;
                    else if (bus.sie_crcerr_i)   r_cpl_err <= 2'd2;
                    else                         r_cpl_err <= 2'd0;
                end
            end
        end
    end
endmodule

// File: tb/tb_usbh_xfer_sched.sv
// Randomized bench for usbh_xfer_sched: SIE responder scripted per request, completions scored
// against outcomes derived from the NAK count and final SIE status.
module tb_usbh_xfer_sched;
    localparam int P  = 100;
    localparam int G  = 20;
    localparam int MR = 15;
    localparam int RG = 8;

    logic clkout2 = 1'b0;
    logic reset   = 1'b1;
    usbh_xfer_sched_if bus();

    usbh_xfer_sched #(.SOF_PERIOD(P), .EOF_GUARD(G), .MAX_RETRY(MR), .RETRY_GAP(RG)) dut (
        .clkout2 (clkout2),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clkout2 = ~clkout2;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference timebase: enabled cycles since reset give timer and frame by plain arithmetic.
    int unsigned cyc;
    int unsigned tick = 0;
    logic [10:0] fm;
    always @(posedge clkout2 or posedge reset)
        if (reset) cyc <= 0;
        else if (bus.sof_en_i) cyc <= cyc + 1;
        else cyc <= 0;
    always @(posedge clkout2) tick <= tick + 1;
    assign fm = 11'((cyc / P) % 2048);

    logic [52:0] outs_a;
    logic [25:0] outs_b;
    assign outs_a = {bus.sie_start_o, bus.req_ready_o, bus.cpl_valid_o, bus.sie_in_o, bus.sie_sof_o,
                     bus.sie_resp_o, bus.sie_data1_o, bus.frame_o, bus.sie_pid_o, bus.sie_dev_o,
                     bus.sie_ep_o, bus.sie_len_o};
    assign outs_b = {bus.cpl_resp_o, bus.cpl_err_o, bus.cpl_rxcnt_o};

    logic [7:0]  cur_pid;
    logic [6:0]  cur_dev;
    logic [3:0]  cur_ep;
    logic [15:0] cur_len;
    logic        cur_in, cur_data1, cur_resp;
    int          script_naks, att, req_starts = 0, sof_starts = 0;
    logic [7:0]  fin_resp;
    logic        fin_to, fin_crc;
    logic [15:0] fin_rx;
    bit          prev_nak;
    int unsigned nak_tick;

    typedef struct packed {logic [7:0] resp; logic [1:0] err; logic [15:0] rx;} cpl_t;
    cpl_t cplq[$];
    always @(negedge clkout2)
        if (bus.cpl_valid_o) cplq.push_back('{bus.cpl_resp_o, bus.cpl_err_o, bus.cpl_rxcnt_o});

    logic        s_sof;
    logic [37:0] s_fields;

    initial begin : sie_model
        bus.sie_ack_i = 1'b0; bus.sie_idle_i = 1'b1; bus.sie_timeout_i = 1'b0;
        bus.sie_crcerr_i = 1'b0; bus.sie_resp_i = 8'h00; bus.sie_rxcnt_i = 16'h0000;
        forever begin
            @(negedge clkout2);
            if (!reset && bus.sie_start_o) begin
                s_sof    = bus.sie_sof_o;
                s_fields = {bus.sie_pid_o, bus.sie_dev_o, bus.sie_ep_o, bus.sie_len_o,
                            bus.sie_in_o, bus.sie_resp_o, bus.sie_data1_o};
                if (s_sof) begin
                    sof_starts++;
                    chk("sof_pid", 64'(bus.sie_pid_o), 64'h A5);
                    chk("sof_quals", 64'({bus.sie_len_o, bus.sie_in_o, bus.sie_resp_o, bus.sie_data1_o}), 64'h0);
                    chk("sof_devep", 64'({bus.sie_ep_o, bus.sie_dev_o}), 64'(fm));
                    chk("frame", 64'(bus.frame_o), 64'(fm));
                end else begin
                    req_starts++;
                    chk("req_fields", 64'(s_fields),
                        64'({cur_pid, cur_dev, cur_ep, cur_len, cur_in, cur_resp, cur_data1}));
                    if (prev_nak) chk("retry_gap", 64'((tick - nak_tick) >= RG), 64'h1);
                end
                repeat (2) @(negedge clkout2);
                chk("start_held", 64'({bus.sie_start_o, bus.sie_pid_o, bus.sie_dev_o, bus.sie_ep_o, bus.sie_len_o,
                                       bus.sie_in_o, bus.sie_resp_o, bus.sie_data1_o}), 64'({1'b1, s_fields}));
                bus.sie_ack_i = 1'b1; bus.sie_idle_i = 1'b0; bus.sie_timeout_i = 1'b0;
                bus.sie_crcerr_i = 1'b0; bus.sie_resp_i = 8'h00; bus.sie_rxcnt_i = 16'h0000;
                @(negedge clkout2);
                bus.sie_ack_i = 1'b0;
                chk("start_drop", 64'(bus.sie_start_o), 64'h0);
                repeat (9) @(negedge clkout2);
                if (!s_sof) begin
                    if (att < script_naks) begin
                        bus.sie_resp_i = 8'h5A;
                        prev_nak = 1'b1;
                        nak_tick = tick;
                    end else begin
                        bus.sie_resp_i = fin_resp; bus.sie_timeout_i = fin_to;
                        bus.sie_crcerr_i = fin_crc; bus.sie_rxcnt_i = fin_rx;
                        prev_nak = 1'b0;
                    end
                    att++;
                end
                bus.sie_idle_i = 1'b1;
            end
        end
    end

    task automatic run_req(input logic [7:0] pid, input logic [6:0] dev, input logic [3:0] ep,
                           input logic [15:0] len, input logic data1, input logic rsp, input int naks,
                           input logic [7:0] fresp, input logic fto, input logic fcrc,
                           input logic [15:0] frx, input bit guard);
        int s0, sofs0, exp_starts, w;
        bit got;
        int unsigned rem;
        cpl_t c, e;
        cur_pid = pid; cur_dev = dev; cur_ep = ep; cur_len = len; cur_in = (pid == 8'h69);
        cur_data1 = data1; cur_resp = rsp;
        script_naks = naks; att = 0; prev_nak = 1'b0;
        fin_resp = fresp; fin_to = fto; fin_crc = fcrc; fin_rx = frx;
        exp_starts = (naks > MR) ? MR + 1 : naks + 1;
        if (naks > MR) e = '{8'h5A, 2'd3, 16'h0};
        else           e = '{fresp, fto ? 2'd1 : (fcrc ? 2'd2 : 2'd0), frx};
        s0 = req_starts;
        sofs0 = sof_starts;
        if (guard) begin
            w = 0;
            while (cyc % P != P - G + 1 && w < 500) begin @(negedge clkout2); #1; w++; end
            sofs0 = sof_starts;
        end
        bus.req_pid_i = pid; bus.req_dev_i = dev; bus.req_ep_i = ep; bus.req_len_i = len;
        bus.req_in_i = cur_in; bus.req_data1_i = data1; bus.req_resp_i = rsp; bus.req_valid_i = 1'b1;
        got = 1'b0;
        rem = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            #1;
            if (bus.req_ready_o) begin got = 1'b1; rem = P - 1 - cyc % P; end
            @(negedge clkout2);
        end
        chk("req_accept", 64'(got), 64'h1);
        if (got) begin
            chk("guard_room", 64'(rem > G), 64'h1);
            if (guard) chk("guard_sof_first", 64'(sof_starts > sofs0), 64'h1);
            #1 chk("ready_pulse", 64'(bus.req_ready_o), 64'h0);
        end
        bus.req_valid_i = 1'b0;
        w = 0;
        while (cplq.size() == 0 && w < 6000) begin @(negedge clkout2); w++; end
        chk("cpl_seen", 64'(cplq.size() != 0), 64'h1);
        if (cplq.size() != 0) begin
            c = cplq.pop_front();
            chk("cpl_resp", 64'(c.resp), 64'(e.resp));
            chk("cpl_err", 64'(c.err), 64'(e.err));
            chk("cpl_rxcnt", 64'(c.rx), 64'(e.rx));
        end
        chk("start_count", 64'(req_starts - s0), 64'(exp_starts));
        repeat (3) @(negedge clkout2);
        chk("single_cpl", 64'(cplq.size()), 64'h0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin : main
        logic [7:0] pid, fresp;
        logic fto, fcrc;
        int naks, r, w, s0;
        bus.sof_en_i = 1'b0; bus.req_valid_i = 1'b0; bus.req_pid_i = 8'h00; bus.req_dev_i = 7'h00;
        bus.req_ep_i = 4'h0; bus.req_len_i = 16'h0000; bus.req_in_i = 1'b0; bus.req_data1_i = 1'b0;
        bus.req_resp_i = 1'b0;
        repeat (3) @(negedge clkout2);
        chk("rst_outs_a", 64'(outs_a), 64'h0);
        chk("rst_outs_b", 64'(outs_b), 64'h0);
        reset = 1'b0;
        bus.sof_en_i = 1'b1;
        repeat (250) @(negedge clkout2);
        chk("sof_count", 64'(sof_starts), 64'd2);
        chk("frame_after_250", 64'(bus.frame_o), 64'd2);
        chk("sof_no_cpl", 64'(cplq.size()), 64'h0);

        run_req(8'h69, 7'd5, 4'd1, 16'd0,  1'b0, 1'b1, 0,  8'h4B, 1'b0, 1'b0, 16'd8, 1'b0);
        run_req(8'hE1, 7'd9, 4'd2, 16'd64, 1'b1, 1'b1, 3,  8'hD2, 1'b0, 1'b0, 16'd0, 1'b0);
        run_req(8'hE1, 7'd9, 4'd2, 16'd64, 1'b0, 1'b1, 20, 8'hD2, 1'b0, 1'b0, 16'd0, 1'b0);
        run_req(8'h2D, 7'd3, 4'd0, 16'd8,  1'b0, 1'b1, 0,  8'hD2, 1'b0, 1'b0, 16'd0, 1'b1);
        run_req(8'h69, 7'd7, 4'd3, 16'd0,  1'b0, 1'b1, 0,  8'h00, 1'b1, 1'b0, 16'd0, 1'b0);
        run_req(8'h69, 7'd7, 4'd3, 16'd0,  1'b0, 1'b1, 0,  8'h4B, 1'b0, 1'b1, 16'd5, 1'b0);

        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 60)) @(negedge clkout2);
            r = $urandom_range(0, 2);
            pid = (r == 0) ? 8'h69 : ((r == 1) ? 8'hE1 : 8'h2D);
            r = $urandom_range(0, 9);
            naks = (r == 0) ? 16 + $urandom_range(0, 2) : ((r < 4) ? $urandom_range(1, 3) : 0);
            fto  = ($urandom_range(0, 5) == 0);
            fcrc = ($urandom_range(0, 4) == 0);
            if (pid == 8'h69) fresp = $urandom_range(0, 1) ? 8'h4B : 8'hC3;
            else              fresp = $urandom_range(0, 1) ? 8'hD2 : 8'h1E;
            if (fto) fresp = 8'h00;
            run_req(pid, 7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)), 16'($urandom_range(0, 1023)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), naks, fresp, fto, fcrc,
                    16'($urandom_range(0, 1023)), 1'b0);
        end

        // Abort a transfer mid-flight with reset.
        cur_pid = 8'h69; cur_dev = 7'd11; cur_ep = 4'd4; cur_len = 16'd0; cur_in = 1'b1;
        cur_data1 = 1'b0; cur_resp = 1'b1; script_naks = 0; att = 0; prev_nak = 1'b0;
        fin_resp = 8'h4B; fin_to = 1'b0; fin_crc = 1'b0; fin_rx = 16'd3;
        bus.req_pid_i = cur_pid; bus.req_dev_i = cur_dev; bus.req_ep_i = cur_ep; bus.req_len_i = cur_len;
        bus.req_in_i = cur_in; bus.req_data1_i = cur_data1; bus.req_resp_i = cur_resp;
        s0 = req_starts;
        bus.req_valid_i = 1'b1;
        w = 0;
        while (req_starts == s0 && w < 3000) begin @(negedge clkout2); w++; end
        bus.req_valid_i = 1'b0;
        chk("rst_req_started", 64'(req_starts - s0), 64'd1);
        repeat (5) @(negedge clkout2);
        reset = 1'b1;
        #1;
        chk("busy_rst_outs_a", 64'(outs_a), 64'h0);
        chk("busy_rst_outs_b", 64'(outs_b), 64'h0);
        @(negedge clkout2);
        reset = 1'b0;
        repeat (40) @(negedge clkout2);
        chk("busy_rst_no_cpl", 64'(cplq.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
